fmadd_round_mul_pipe: RTL

FMADD_ROUND_MUL_PIPE -- requirements
Module: fmadd_round_mul_pipe

---
 rtl/fmadd_round_mul_pipe_pkg.sv | 35 +++
 rtl/fmadd_round_sat.sv | 32 +++
 rtl/fmadd_round_mul_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fmadd_round_mul_pipe_pkg.sv
// Shared definitions for the multiplier rounding pipeline: rounding-mode codes,
// flag bit positions and the round-increment decision.
package fmadd_round_mul_pipe_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_INX = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;

  // Directed modes also round on sticky bits lost by the preceding normaliser.
  // Unknown codes fall through to truncation.
  function automatic logic calc_inc(input logic [2:0] rm, input logic sign,
                                    input logic g, input logic r, input logic s,
                                    input logic m_lsb, input logic sticky_pn,
                                    input logic ovf_in);
    logic inc;
    inc = 1'b0;
    if (!ovf_in) begin
      case (rm)
        RM_RNE:  inc = g & (r | s | m_lsb);
        RM_RMM:  inc = g;
        RM_RUP:  inc = ~sign & (g | r | s | sticky_pn);
        RM_RDN:  inc = sign & (g | r | s | sticky_pn);
        default: inc = 1'b0;
      endcase
    end
    return inc;
  endfunction

endpackage

// File: rtl/fmadd_round_sat.sv
// Saturation value for an overflowing result: signed infinity or signed
// max-finite, chosen by the rounding direction.
module fmadd_round_sat
  import fmadd_round_mul_pipe_pkg::*;
#(
  parameter int MAN = 6,
  parameter int EXP = 7,
  parameter int STD = 15
) (
  input  logic           sign,
  input  logic [2:0]     rm,
  output logic [STD:0]   sat_val
);

  logic [STD:0] inf_val;
  logic [STD:0] max_val;

  assign inf_val = {sign, {(EXP+1){1'b1}}, {(MAN+1){1'b0}}};
  assign max_val = {sign, {EXP{1'b1}}, 1'b0, {(MAN+1){1'b1}}};

  // Rounding toward the sign's direction reaches infinity, away from it clamps.
  always_comb begin
    sat_val = max_val;
    case (rm)
      RM_RNE, RM_RMM: sat_val = inf_val;
      RM_RUP:         sat_val = sign ? max_val : inf_val;
      RM_RDN:         sat_val = sign ? inf_val : max_val;
      default:        sat_val = max_val;
    endcase
  end

endmodule

// File: rtl/fmadd_round_mul_pipe.sv
// Two-stage rounding back end for the multiplier: rounds the normalised product,
// saturates on overflow, and keeps sticky exception flags.
module fmadd_round_mul_pipe
  import fmadd_round_mul_pipe_pkg::*;
#(
  parameter int MAN = 6,
  parameter int EXP = 7,
  parameter int STD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*MAN+EXP+5:0] in_no,
  input  logic [2:0]           in_rm,
  input  logic                 in_overflow,
  input  logic                 in_sticky_pn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STD:0]         out_no,
  output logic [2:0]           out_flags,
  output logic [2:0]           acc_flags,
  input  logic                 acc_clr
);

  localparam int PW = 2*MAN + 4;

  logic           en;
  logic           sign_in;
  logic [EXP:0]   exp_in;
  logic [PW-1:0]  prod;
  logic [MAN+1:0] m_in;
  logic           g, r, s;
  logic [STD:0]   sat_in;

  logic           s1_valid;
  logic           s1_sign;
  logic [EXP:0]   s1_exp;
  logic [MAN+1:0] s1_m;
  logic           s1_inc;
  logic           s1_ovf_in;
  logic           s1_unf;
  logic           s1_inx;
  logic [STD:0]   s1_sat;

  logic [MAN+1:0] sum;
  logic [EXP:0]   exp_r;
  logic           ovf;
  logic [STD:0]   res;
  logic [2:0]     flags;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign sign_in = in_no[PW+EXP+1];
  assign exp_in  = in_no[PW +: EXP+1];
  assign prod    = in_no[PW-1:0];
  assign m_in    = prod[PW-1:MAN+2];
  assign g       = prod[MAN+1];
  assign r       = prod[MAN];
  assign s       = |prod[MAN-1:0];

  fmadd_round_sat #(.MAN(MAN), .EXP(EXP), .STD(STD)) u_sat (
    .sign    (sign_in),
    .rm      (in_rm),
    .sat_val (sat_in)
  );

  // Stage 1 captures the fields plus the rounding and saturation decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_m      <= '0;
      s1_inc    <= 1'b0;
      s1_ovf_in <= 1'b0;
      s1_unf    <= 1'b0;
      s1_inx    <= 1'b0;
      s1_sat    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= sign_in;
        s1_exp    <= exp_in;
        s1_m      <= m_in;
        s1_inc    <= calc_inc(in_rm, sign_in, g, r, s, m_in[0], in_sticky_pn, in_overflow);
        s1_ovf_in <= in_overflow;
        s1_unf    <= (exp_in == '0) && (m_in == '0);
        s1_inx    <= g | r | s | in_sticky_pn;
        s1_sat    <= sat_in;
      end
    end
  end

  // A carry out of the mantissa wraps; only a fresh MSB bumps the exponent.
  always_comb begin
    sum   = s1_m + {{(MAN+1){1'b0}}, s1_inc};
    exp_r = s1_exp + {{EXP{1'b0}}, ~s1_m[MAN+1] & sum[MAN+1]};
    ovf   = (exp_r == {(EXP+1){1'b1}}) | s1_ovf_in;
    res   = ovf ? s1_sat : {s1_sign, exp_r, sum[MAN:0]};
    flags = '0;
    flags[FLAG_OVF] = ovf;
    flags[FLAG_UNF] = s1_unf;
    flags[FLAG_INX] = s1_inx | ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_no    <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_no    <= res;
        out_flags <= flags;
      end
    end
  end

  // Clear beats capture when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_flags <= '0;
    end else if (acc_clr) begin
      acc_flags <= '0;
    end else if (out_valid && out_ready) begin
      acc_flags <= acc_flags | out_flags;
    end
  end

endmodule
